flag_bank_br_unit: RTL

//  Banked condition-flag register file with branch-condition resolution.
//  - Holds NSETS independent flag sets (Z/N/V/C), each written by ALU flag writeback with a per-bit mask.
//  - A per-set pending scoreboard stalls branches whose flags are still in flight; optional same-cycle write bypass.
//  - Sits between ALU flag writeback and the fetch/PC unit; br_taken drives PC redirect.

---
 rtl/flag_bank_br_unit_pkg.sv | 24 ++
 rtl/flag_bank_br_unit_if.sv | 39 +++
 rtl/flag_bank_br_unit_cond.sv | 35 +++
 rtl/flag_bank_br_unit.sv | 97 +++++++++
 4 files changed

// File: rtl/flag_bank_br_unit_pkg.sv
// Shared definitions for the flag bank / branch unit: flag bit positions,
// default widths and the branch condition codes.
package flag_bank_br_unit_pkg;

    localparam int unsigned FR_FLAG_W = 4;
    localparam int unsigned FR_FUNC_W = 3;

    localparam int unsigned Z_FLAG = 0;
    localparam int unsigned N_FLAG = 1;
    localparam int unsigned V_FLAG = 2;
    localparam int unsigned C_FLAG = 3;

    typedef enum logic [FR_FUNC_W-1:0] {
        FR_BAL      = 3'd0,
        FR_BEQ      = 3'd1,
        FR_BNE      = 3'd2,
        FR_BLT      = 3'd3,
        FR_BGE      = 3'd4,
        FR_BLTU_BC  = 3'd5,
        FR_BGEU_BNC = 3'd6,
        FR_BVF      = 3'd7
    } br_func_e;

endpackage

// File: rtl/flag_bank_br_unit_if.sv
// Flag writeback, pending-mark and branch request/result bundle between the
// ALU side, the fetch/PC unit and the flag bank.
interface flag_bank_br_unit_if
    import flag_bank_br_unit_pkg::*;
#(
    parameter int unsigned FLAG_W = FR_FLAG_W,
    parameter int unsigned FUNC_W = FR_FUNC_W,
    parameter int unsigned NSETS  = 4,
    parameter int unsigned CNT_W  = 16
);
    localparam int unsigned SET_W = (NSETS > 1) ? $clog2(NSETS) : 1;

    logic              fl_we;
    logic [SET_W-1:0]  fl_wsel;
    logic [FLAG_W-1:0] fl_wdata;
    logic [FLAG_W-1:0] fl_wmask;
    logic              fl_pend_set;
    logic [SET_W-1:0]  fl_pend_sel;
    logic              br_valid;
    logic              br_ready;
    logic [FUNC_W-1:0] br_func;
    logic [SET_W-1:0]  br_sel;
    logic              res_valid;
    logic              br_taken;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output fl_we, fl_wsel, fl_wdata, fl_wmask, fl_pend_set, fl_pend_sel,
        output br_valid, br_func, br_sel,
        input  br_ready, res_valid, br_taken, stall_cnt
    );

    modport slave (
        input  fl_we, fl_wsel, fl_wdata, fl_wmask, fl_pend_set, fl_pend_sel,
        input  br_valid, br_func, br_sel,
        output br_ready, res_valid, br_taken, stall_cnt
    );

endinterface

// File: rtl/flag_bank_br_unit_cond.sv
// Combinational branch condition evaluator: flag set + function code -> taken.
module br_cond_eval
    import flag_bank_br_unit_pkg::*;
#(
    parameter int unsigned FLAG_W = FR_FLAG_W,
    parameter int unsigned FUNC_W = FR_FUNC_W
) (
    input  logic [FLAG_W-1:0] i_flags,
    input  logic [FUNC_W-1:0] i_func,
    output logic              o_cond
);
    logic w_z, w_n, w_v, w_c;

    assign w_z = i_flags[Z_FLAG];
    assign w_n = i_flags[N_FLAG];
    assign w_v = i_flags[V_FLAG];
    assign w_c = i_flags[C_FLAG];

    // Codes beyond the defined set (only reachable when FUNC_W is widened) are never taken.
    always_comb begin
        o_cond = 1'b0;
        case (i_func)
            FUNC_W'(FR_BAL):      o_cond = 1'b1;
            FUNC_W'(FR_BEQ):      o_cond = w_z;
            FUNC_W'(FR_BNE):      o_cond = !w_z;
            FUNC_W'(FR_BLT):      o_cond = (w_n != w_v);
            FUNC_W'(FR_BGE):      o_cond = (w_n == w_v);
            FUNC_W'(FR_BLTU_BC):  o_cond = w_c;
            FUNC_W'(FR_BGEU_BNC): o_cond = !w_c;
            FUNC_W'(FR_BVF):      o_cond = w_v;
            default:              o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_bank_br_unit.sv
// Banked Z/N/V/C flag register file with pending scoreboard, optional
// same-cycle write bypass, registered branch resolution and stall counter.
module flag_bank_br_unit
    import flag_bank_br_unit_pkg::*;
#(
    parameter int unsigned FLAG_W = FR_FLAG_W,
    parameter int unsigned FUNC_W = FR_FUNC_W,
    parameter int unsigned NSETS  = 4,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic clock,
    input  logic rst,
    flag_bank_br_unit_if.slave fb
);
    localparam int unsigned SET_W = (NSETS > 1) ? $clog2(NSETS) : 1;
    localparam int unsigned NSLOT = 1 << SET_W;

    logic [FLAG_W-1:0] r_flags [NSLOT];
    logic [NSLOT-1:0]  r_pend;
    logic              r_res_valid;
    logic              r_br_taken;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [NSLOT-1:0]  w_pend_next;
    logic              w_wsel_ok;
    logic              w_psel_ok;
    logic              w_bypass;
    logic              w_ready;
    logic              w_accept;
    logic              w_cond;
    logic [FLAG_W-1:0] w_old;
    logic [FLAG_W-1:0] w_eff;

    function automatic logic sel_in_range(input logic [SET_W-1:0] sel);
        return 32'(sel) < NSETS;
    endfunction

    // Slots past NSETS are never written or marked, so they read as zero flags, never pending.
    assign w_wsel_ok = sel_in_range(fb.fl_wsel);
    assign w_psel_ok = sel_in_range(fb.fl_pend_sel);

    assign w_old    = r_flags[fb.br_sel];
    assign w_bypass = (BYPASS != 0) && fb.fl_we && w_wsel_ok && (fb.fl_wsel == fb.br_sel);
    assign w_eff    = w_bypass ? ((w_old & ~fb.fl_wmask) | (fb.fl_wdata & fb.fl_wmask)) : w_old;
    assign w_ready  = !r_pend[fb.br_sel] || w_bypass;
    assign w_accept = fb.br_valid && w_ready;

    br_cond_eval #(
        .FLAG_W (FLAG_W),
        .FUNC_W (FUNC_W)
    ) u_cond (
        .i_flags (w_eff),
        .i_func  (fb.br_func),
        .o_cond  (w_cond)
    );

    // A new producer mark beats a same-cycle writeback clear on the same set.
    always_comb begin
        w_pend_next = r_pend;
        if (fb.fl_we && w_wsel_ok) begin
            w_pend_next[fb.fl_wsel] = 1'b0;
        end
        if (fb.fl_pend_set && w_psel_ok) begin
            w_pend_next[fb.fl_pend_sel] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                r_flags[i] <= '0;
            end
            r_pend      <= '0;
            r_res_valid <= 1'b0;
            r_br_taken  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (fb.fl_we && w_wsel_ok) begin
                r_flags[fb.fl_wsel] <= (r_flags[fb.fl_wsel] & ~fb.fl_wmask) |
                                       (fb.fl_wdata & fb.fl_wmask);
            end
            r_pend      <= w_pend_next;
            r_res_valid <= w_accept;
            r_br_taken  <= w_accept && w_cond;
            if (fb.br_valid && !w_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign fb.br_ready  = w_ready;
    assign fb.res_valid = r_res_valid;
    assign fb.br_taken  = r_br_taken;
    assign fb.stall_cnt = r_stall_cnt;

endmodule
